// File: rtl/shift_add_mult16_pkg.sv
// Shared definitions for the 16x16 shift-add multiplier.
//   state_e : FSM encoding (IDLE, RUN, DONE)
//   N       : operand width
//   ITER    : number of RUN iterations (one per multiplier bit)
package shift_add_mult16_pkg;

  localparam int N    = 16;
  localparam int ITER = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/carrySkip32.sv
// 32-bit carry-skip adder built from 4-bit ripple blocks.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin (low 32 bits)
//   cout : carry out
// A block whose bits all propagate forwards its incoming carry directly
// instead of waiting for the internal ripple.
module carrySkip32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  localparam int BLK = 4;
  localparam int NB  = 32 / BLK;

  logic c, cblk, p, p_all;

  always_comb begin
    c     = cin;
    cblk  = 1'b0;
    p     = 1'b0;
    p_all = 1'b0;
    sum   = '0;
    for (int g = 0; g < NB; g++) begin
      cblk  = c;
      p_all = 1'b1;
      for (int k = 0; k < BLK; k++) begin
        p                = a[g*BLK+k] ^ b[g*BLK+k];
        sum[g*BLK+k]     = p ^ c;
        c                = (a[g*BLK+k] & b[g*BLK+k]) | (p & c);
        p_all            = p_all & p;
      end
      // skip path: full-propagate block passes its input carry through
      c = p_all ? cblk : c;
    end
    cout = c;
  end

endmodule

// File: rtl/shift_add_mult16.sv
// Sequential unsigned 16x16 shift-add multiplier, one multiplier bit per cycle.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   start   : request, sampled only in IDLE
//   a, b    : multiplicand / multiplier, captured on the accepted start
//   busy    : high while iterating (RUN)
//   done    : one-cycle completion pulse (DONE)
//   product : 32-bit result, held until the next completion
module shift_add_mult16
  import shift_add_mult16_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  state_e          state_q, state_d;
  logic [2*N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [2*N-1:0]  product_q, product_d;

  logic [2*N-1:0]  addend, sum;

  assign addend = mplier_q[0] ? mcand_q : '0;

  // 16x16 cannot exceed 32 bits, so the carry-out is not needed
  carrySkip32 u_add (
    .a    (acc_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout ()
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: if (start) begin
        mcand_d  = {{N{1'b0}}, a};
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = RUN;
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        // fixed ITER edges, no early exit on a zero multiplier
        if (cnt_q == 5'(ITER - 1)) begin
          product_d = sum;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult16.sv
module tb_shift_add_mult16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [31:0] product;

  int total = 0;
  int bad   = 0;

  shift_add_mult16 #(.N(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accepts one start from IDLE, scrambles a/b afterwards, waits for done.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [31:0] exp);
    int lat, bcy;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    lat = 0; bcy = 0;
    while (!done && lat < 40) begin
      if (busy) bcy++;
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, 16);
    chk({tag, " busy_cycles"}, bcy, 16);
    chk({tag, " product"}, product, exp);
    tick();
    chk({tag, " done_one_cycle"}, {31'b0, done}, 0);
    chk({tag, " product_held"}, product, exp);
  endtask

  initial begin
    int lat, dcnt, nd;
    int t[3];
    logic [31:0] pp[3];

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset product", product, 0);

    // reset wins over start
    start = 1'b1; a = 16'd9; b = 16'd9;
    tick();
    chk("rst_prio busy", {31'b0, busy}, 0);
    // first edge with rst low honours start
    rst = 1'b0;
    tick();
    start = 1'b0;
    chk("post_rst start busy", {31'b0, busy}, 1);
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    chk("post_rst product", product, 32'd81);
    tick();

    run_op("3x5", 16'd3, 16'd5, 32'h0000_000F);
    run_op("ffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    run_op("1234x0", 16'h1234, 16'h0000, 32'h0000_0000);

    // start during RUN is ignored
    a = 16'd3; b = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    a = 16'd7; b = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ignore product_unchanged_in_run", product, 32'h0);
    lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    chk("ignore product", product, 32'd15);
    tick();

    // reset mid-run aborts with no done pulse
    a = 16'hFFFF; b = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", {31'b0, busy}, 0);
    chk("abort product", product, 0);
    dcnt = 0;
    repeat (20) begin
      if (done) dcnt++;
      tick();
    end
    chk("abort no_done", dcnt, 0);
    run_op("6x7", 16'd6, 16'd7, 32'd42);

    // inputs moving while idle do not touch product
    a = 16'hABCD; b = 16'h1234;
    tick(); tick();
    chk("idle product_hold", product, 32'd42);

    // start held high: back-to-back every 18 cycles
    a = 16'd2; b = 16'd3; start = 1'b1;
    nd = 0; lat = 0;
    while (nd < 3 && lat < 80) begin
      tick();
      lat++;
      if (done) begin t[nd] = lat; pp[nd] = product; nd++; end
    end
    start = 1'b0;
    chk("b2b pulses", nd, 3);
    if (nd == 3) begin
      chk("b2b spacing1", t[1] - t[0], 18);
      chk("b2b spacing2", t[2] - t[1], 18);
      chk("b2b product0", pp[0], 32'd6);
      chk("b2b product2", pp[2], 32'd6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
